// File: rtl/mfp_ahb_gpio_ext.sv
// AHB-Lite GPIO: synchronised inputs, set/clear/toggle outputs.
// Define MFP_GPIO_IRQ_EN to add per-pin edge interrupts at offsets 5-7.
module mfp_ahb_gpio_ext #(
  parameter int N_IN        = 16,
  parameter int N_OUT       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [5:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HSEL,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  localparam logic [2:0] A_IN   = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_SET  = 3'd2;
  localparam logic [2:0] A_CLR  = 3'd3;
  localparam logic [2:0] A_TGL  = 3'd4;
  localparam logic [2:0] A_EN   = 3'd5;
  localparam logic [2:0] A_RISE = 3'd6;
  localparam logic [2:0] A_PEND = 3'd7;

  logic [2:0]       addr_q;
  logic             hwrite_q;
  logic             hsel_q;
  logic [1:0]       htrans_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  sync_q [SYNC_STAGES];
  logic [N_IN-1:0]  sync_d [SYNC_STAGES];
  logic [N_IN-1:0]  in_sync;
  logic             wr_en;
  logic [N_OUT-1:0] wdat_out;
  logic [N_IN-1:0]  wdat_in;
  logic             unused_haddr;

  assign unused_haddr = ^{HADDR[5], HADDR[1:0]};

  assign wr_en    = hsel_q & hwrite_q & (htrans_q != 2'b00);
  assign wdat_out = HWDATA[N_OUT-1:0];
  assign wdat_in  = HWDATA[N_IN-1:0];
  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign gpio_out = out_q;
  assign HRDATA   = rdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      hwrite_q <= 1'b0;
      hsel_q   <= 1'b0;
      htrans_q <= 2'b00;
      rdata_q  <= '0;
      out_q    <= '0;
      sync_q   <= '{default: '0};
    end else begin
      addr_q   <= HADDR[4:2];
      hwrite_q <= HWRITE;
      hsel_q   <= HSEL;
      htrans_q <= HTRANS;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      sync_q   <= sync_d;
    end
  end

  always_comb begin
    sync_d[0] = gpio_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_comb begin
    out_d = out_q;
    if (wr_en) begin
      case (addr_q)
        A_OUT:   out_d = wdat_out;
        A_SET:   out_d = out_q | wdat_out;
        A_CLR:   out_d = out_q & ~wdat_out;
        A_TGL:   out_d = out_q ^ wdat_out;
        default: out_d = out_q;
      endcase
    end
  end

`ifdef MFP_GPIO_IRQ_EN
  logic [N_IN-1:0] en_q, en_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] pend_q, pend_d;
  logic [N_IN-1:0] prev_q;
  logic [N_IN-1:0] event_w;
  logic [N_IN-1:0] w1c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q   <= '0;
      rise_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      en_q   <= en_d;
      rise_q <= rise_d;
      pend_q <= pend_d;
      prev_q <= in_sync;
    end
  end

  always_comb begin
    en_d   = en_q;
    rise_d = rise_q;
    w1c    = '0;
    if (wr_en) begin
      case (addr_q)
        A_EN:    en_d   = wdat_in;
        A_RISE:  rise_d = wdat_in;
        A_PEND:  w1c    = wdat_in;
        default: w1c    = '0;
      endcase
    end
    event_w = (rise_q & in_sync & ~prev_q)
            | (~rise_q & ~in_sync & prev_q);
    // a new event outranks a same-cycle clear
    pend_d  = (pend_q & ~w1c) | (event_w & en_q);
  end

  assign irq = |pend_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (HADDR[4:2])
      A_IN:    rdata_d = 32'(in_sync);
      A_OUT:   rdata_d = 32'(out_q);
`ifdef MFP_GPIO_IRQ_EN
      A_EN:    rdata_d = 32'(en_q);
      A_RISE:  rdata_d = 32'(rise_q);
      A_PEND:  rdata_d = 32'(pend_q);
`endif
      default: rdata_d = '0;
    endcase
  end

endmodule

// File: tb/tb_mfp_ahb_gpio_ext.sv
// Directed bench for mfp_ahb_gpio_ext; IRQ scenarios follow
// the MFP_GPIO_IRQ_EN build option.
module tb_mfp_ahb_gpio_ext;

  localparam int NI   = 16;
  localparam int NO   = 16;
  localparam int SYNC = 2;

  localparam logic [5:0] R_IN   = 6'h00;
  localparam logic [5:0] R_OUT  = 6'h04;
  localparam logic [5:0] R_SET  = 6'h08;
  localparam logic [5:0] R_CLR  = 6'h0C;
  localparam logic [5:0] R_TGL  = 6'h10;
  localparam logic [5:0] R_EN   = 6'h14;
  localparam logic [5:0] R_RISE = 6'h18;
  localparam logic [5:0] R_PEND = 6'h1C;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [5:0]    HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic          HSEL;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic [NI-1:0] gpio_in;
  logic [NO-1:0] gpio_out;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_gpio_ext #(
    .N_IN(NI), .N_OUT(NO), .SYNC_STAGES(SYNC)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSEL(HSEL),
    .HWDATA(HWDATA), .HRDATA(HRDATA),
    .gpio_in(gpio_in), .gpio_out(gpio_out),
    .irq(irq)
  );

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [5:0] a, input logic [31:0] d);
    HADDR = a; HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HWDATA = d; HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [5:0] a, output logic [31:0] d);
    HADDR = a; HSEL = 1'b1; HWRITE = 1'b0; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    d = HRDATA; HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSEL = 1'b0; HWDATA = '0; gpio_in = '0;
    idle(3);
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA);
    end
    checks++;
    if (gpio_out !== '0) begin
      errors++; $display("FAIL reset_out: got %h want 0", gpio_out);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    HRESETn = 1'b1;
    idle(2);
  endtask

  task automatic test_out_ops();
    logic [31:0] rd;
    ahb_write(R_OUT, 32'h0000_00AA);
    checks++;
    if (gpio_out !== 16'h00AA) begin
      errors++; $display("FAIL out_wr: got %h want 00aa", gpio_out);
    end
    ahb_write(R_SET, 32'h0000_0005);
    checks++;
    if (gpio_out !== 16'h00AF) begin
      errors++; $display("FAIL out_set: got %h want 00af", gpio_out);
    end
    ahb_read(R_OUT, rd);
    checks++;
    if (rd !== 32'h0000_00AF) begin
      errors++; $display("FAIL out_rd: got %h want 000000af", rd);
    end
    ahb_write(R_TGL, 32'h0000_00FF);
    checks++;
    if (gpio_out !== 16'h0050) begin
      errors++; $display("FAIL out_tgl: got %h want 0050", gpio_out);
    end
    ahb_write(R_CLR, 32'h0000_0010);
    checks++;
    if (gpio_out !== 16'h0040) begin
      errors++; $display("FAIL out_clr: got %h want 0040", gpio_out);
    end
    ahb_read(R_SET, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL wo_read: got %h want 0", rd);
    end
    ahb_write(R_OUT, 32'hFFFF_0040);
    ahb_read(R_OUT, rd);
    checks++;
    if (rd !== 32'h0000_0040) begin
      errors++; $display("FAIL out_upper: got %h want 00000040", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    HADDR = R_OUT; HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HWDATA = 32'h0000_1234; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    rd = HRDATA; HSEL = 1'b0; HTRANS = 2'b00;
    checks++;
    if (rd !== 32'h0000_0040) begin
      errors++; $display("FAIL b2b_old: got %h want 00000040", rd);
    end
    checks++;
    if (gpio_out !== 16'h1234) begin
      errors++; $display("FAIL b2b_out: got %h want 1234", gpio_out);
    end
    ahb_read(R_OUT, rd);
    checks++;
    if (rd !== 32'h0000_1234) begin
      errors++; $display("FAIL b2b_new: got %h want 00001234", rd);
    end
  endtask

`ifdef MFP_GPIO_IRQ_EN
  task automatic test_irq_rise();
    logic [31:0] rd;
    ahb_write(R_EN, 32'h1);
    ahb_write(R_RISE, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (SYNC) @(posedge HCLK);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_early: got %b want 0", irq);
    end
    @(posedge HCLK); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %b want 1", irq);
    end
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL pend_rise: got %h want 1", rd);
    end
    ahb_write(R_PEND, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_w1c: got %b want 0", irq);
    end
  endtask

  task automatic test_irq_fall();
    logic [31:0] rd;
    ahb_write(R_EN, 32'h9);
    gpio_in[3] = 1'b1;
    idle(SYNC + 3);
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL fall_norise: got %h want 0", rd);
    end
    gpio_in[3] = 1'b0;
    idle(SYNC + 3);
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h8 || irq !== 1'b1) begin
      errors++;
      $display("FAIL fall_pend: got %h irq %b want 8 irq 1", rd, irq);
    end
    gpio_in[3] = 1'b1;
    idle(SYNC + 3);
    ahb_write(R_EN, 32'h1);
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h8) begin
      errors++; $display("FAIL pend_hold: got %h want 8", rd);
    end
    ahb_write(R_PEND, 32'h8);
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL fall_w1c: got %h want 0", rd);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    gpio_in[0] = 1'b0;
    idle(SYNC + 3);
    gpio_in[0] = 1'b1;
    repeat (SYNC - 1) @(posedge HCLK);
    #1;
    ahb_write(R_PEND, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL setwin_irq: got %b want 1", irq);
    end
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL setwin_pend: got %h want 1", rd);
    end
    ahb_write(R_PEND, 32'h1);
  endtask
`else
  task automatic test_no_irq();
    logic [31:0] rd;
    ahb_write(R_EN, 32'hFFFF);
    ahb_write(R_RISE, 32'hFFFF);
    ahb_write(R_PEND, 32'hFFFF);
    for (int r = 5; r < 8; r++) begin
      ahb_read(6'(r * 4), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL noirq_rd%0d: got %h want 0", r, rd);
      end
    end
    gpio_in[0] = 1'b1;
    idle(SYNC + 3);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL noirq_irq: got %b want 0", irq);
    end
  endtask
`endif

  task automatic test_inputs();
    logic [31:0] rd;
    gpio_in = '0;
    idle(SYNC + 3);
    gpio_in = 16'h1234;
    for (int k = 1; k <= SYNC + 1; k++) begin
      ahb_read(R_IN, rd);
      checks++;
      if (k <= SYNC && rd !== 32'h0) begin
        errors++; $display("FAIL in_lat%0d: got %h want 0", k, rd);
      end else if (k > SYNC && rd !== 32'h0000_1234) begin
        errors++; $display("FAIL in_val: got %h want 00001234", rd);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    HADDR = R_OUT; HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HWDATA = 32'h0000_BEEF; HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (gpio_out !== '0 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: out %h rd %h want 0 0", gpio_out, HRDATA);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    checks++;
    if (gpio_out !== '0) begin
      errors++; $display("FAIL rst_abort: got %h want 0", gpio_out);
    end
    idle(SYNC + 3);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL rst_irq: got %b want 0", irq);
    end
`ifdef MFP_GPIO_IRQ_EN
    ahb_read(R_PEND, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL rst_pend: got %h want 0", rd);
    end
`endif
    ahb_read(R_OUT, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL rst_out_rd: got %h want 0", rd);
    end
    ahb_read(R_IN, rd);
    checks++;
    if (rd !== 32'h0000_1234) begin
      errors++; $display("FAIL rst_in: got %h want 00001234", rd);
    end
  endtask

  initial begin
    test_reset();
    test_out_ops();
    test_back_to_back();
`ifdef MFP_GPIO_IRQ_EN
    test_irq_rise();
    test_irq_fall();
    test_set_wins();
`else
    test_no_irq();
`endif
    test_inputs();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_gpio_ext.md
MFP_AHB_GPIO_EXT -- requirements
Module: mfp_ahb_gpio_ext

Interface
REQ-001 The block SHALL expose parameter N_IN, default 16: number of general-purpose inputs, legal range 1-32.
REQ-002 The block SHALL expose parameter N_OUT, default 16: number of general-purpose outputs, legal range 1-32.
REQ-003 The block SHALL expose parameter SYNC_STAGES, default 2: synchroniser depth on inputs, legal range 2-3.
REQ-004 The block SHALL have port HCLK, input, 1 bit: clock; all flops on rising edge.
REQ-005 The block SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port HADDR, input, 6 bits: byte address; register select is HADDR[4:2].
REQ-007 The block SHALL have ports HTRANS (input, 2 bits), HWRITE (input, 1 bit), HSEL (input, 1 bit) and HWDATA (input, 32 bits): AHB-Lite slave controls and write data.
REQ-008 The block SHALL have port HRDATA, output, 32 bits: registered read data.
REQ-009 The block SHALL have port gpio_in, input, N_IN bits: asynchronous external inputs.
REQ-010 The block SHALL have port gpio_out, output, N_OUT bits: registered output pins.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt equal to the OR of all pending bits.

Function
REQ-012 The block SHALL implement this register map (HADDR[4:2]):
- 0 IN: RO; synchronised inputs.
- 1 OUT: RW.
- 2 OUT_SET: WO; write-1 sets.
- 3 OUT_CLR: WO; write-1 clears.
- 4 OUT_TGL: WO; write-1 toggles.
- 5 IRQ_EN: RW.
- 6 IRQ_RISE: RW; 1 selects rising edge, 0 selects falling edge.
- 7 IRQ_PEND: R, W1C.
REQ-013 The block SHALL register HADDR, HWRITE, HSEL and HTRANS in the address phase, and SHALL perform the write with HWDATA in the following cycle when the registered HTRANS != IDLE, HSEL = 1 and HWRITE = 1.
REQ-014 The block SHALL return read data in HRDATA one clock after the address phase, decoded from the live HADDR; unused upper bits and WO registers SHALL read 0.
REQ-015 A read whose address phase overlaps the data phase of a write to the same register SHALL return the pre-write value.
REQ-016 Each gpio_in bit SHALL pass through SYNC_STAGES flops; an input stable before clock edge 1 SHALL be visible in IN after edge SYNC_STAGES.
REQ-017 The block SHALL keep a previous-value register of the synchronised inputs; an edge event for bit i SHALL occur when the synchronised and previous values differ in the direction selected by IRQ_RISE[i].
REQ-018 An edge event on bit i with IRQ_EN[i] = 1 SHALL set IRQ_PEND[i] on the next edge (edge SYNC_STAGES+1 after the input change); irq SHALL be high in the same cycle.
REQ-019 If an edge event and a W1C of the same pending bit occur in one cycle, set SHALL win.
REQ-020 Clearing IRQ_EN[i] SHALL NOT clear an already-set IRQ_PEND[i].
REQ-021 Writes to OUT_SET/CLR/TGL SHALL modify only bits written as 1; all other bits SHALL hold.
REQ-022 gpio_out SHALL update one clock after the write data phase.
REQ-023 HWDATA bits at or above N_OUT (or N_IN for IRQ registers) SHALL be ignored.

Reset
REQ-024 While HRESETn = 0 the block SHALL force all of the following to 0: HRDATA, gpio_out (OUT), IRQ_EN, IRQ_RISE, IRQ_PEND, the synchroniser flops, the previous-value register and irq.
REQ-025 After reset, a high input SHALL generate a rising edge event, which SHALL be suppressed because IRQ_EN = 0.
REQ-026 Reset asserted mid-transfer SHALL abort the write, with no partial update.

Configuration
REQ-027 With MFP_GPIO_IRQ_EN defined, the block SHALL include the IRQ_EN, IRQ_RISE and IRQ_PEND registers and the edge logic per REQ-017 to REQ-020.
REQ-028 Without MFP_GPIO_IRQ_EN defined, offsets 5-7 SHALL read 0, writes to them SHALL be ignored, irq SHALL be tied 0, and no edge logic SHALL be instantiated.

Verification
REQ-029 The bench SHALL write 0x00AA to OUT, then 0x0005 to OUT_SET -> gpio_out = 0x00AF, and a read of OUT returns 0x000000AF.
REQ-030 The bench SHALL write 0x00FF to OUT_TGL with OUT = 0x00AF -> gpio_out = 0x0050; then write 0x0010 to OUT_CLR -> gpio_out = 0x0040.
REQ-031 The bench SHALL set IRQ_EN = 0x0001 and IRQ_RISE = 0x0001, drive gpio_in[0] 0->1 -> IRQ_PEND = 0x1 and irq = 1 at edge SYNC_STAGES+1; W1C 0x1 -> irq = 0 on the next cycle.
REQ-032 The bench SHALL apply a falling edge on bit 3 with IRQ_RISE[3] = 0 and IRQ_EN[3] = 1 -> IRQ_PEND = 0x8; a rising edge on bit 3 -> no change.
REQ-033 The bench SHALL issue a W1C of bit 0 in the same cycle as a new bit-0 edge event -> IRQ_PEND[0] remains 1.
REQ-034 The bench SHALL set gpio_in = 0x1234 and read IN -> 0x00001234; then assert HRESETn low mid-write to OUT -> gpio_out = 0 with no write applied.
